// File: rtl/ltl_symbol_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ltl_symbol_tx_if
// Description : Event channel between the core-side event encoder and the
//               monitor symbol transmitter.
//               ev_valid - event symbol valid        (encoder -> tx)
//               ev_ready - transmitter can accept    (tx -> encoder)
//               ev_sym   - 8-bit encoded symbol      (encoder -> tx)
//               flush    - end of trace marker       (encoder -> tx)
// Revision    : 1.0 - initial release
// ============================================================================
interface ltl_symbol_tx_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_sym;
  logic       flush;

  modport master (output ev_valid, ev_sym, flush, input ev_ready);
  modport slave  (input ev_valid, ev_sym, flush, output ev_ready);
endinterface
`default_nettype wire

// File: rtl/ltl_symbol_tx.sv
`default_nettype none
// ============================================================================
// Module      : ltl_symbol_tx
// Description : Transmit side of the 8-bit monitor symbol interface. Buffers
//               encoded trace events in a FIFO and streams them one per cycle
//               into a monitor cluster, sequencing the monitor reset so the
//               first symbol coincides with start_of_data, and tags monitor
//               reports with the index of the symbol that produced them.
// Ports       : clk, reset_n         - clock, async active-low reset
//               ev (slave)           - event channel (valid/ready/sym/flush)
//               mon_reset_o/run_o/symbols_o - monitor drive
//               report_i             - monitor report bits
//               report_valid_o/bits_o/idx_o - tagged report
//               overflow_o           - sticky drop flag, cleared on re-arm
// Revision    : 1.0 - initial release
// ============================================================================
module ltl_symbol_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int ARM_CYCLES = 2,
  parameter int IDX_W      = 16
) (
  input  wire              clk,
  input  wire              reset_n,
  ltl_symbol_tx_if.slave   ev,
  output logic             mon_reset_o,
  output logic             mon_run_o,
  output logic [7:0]       mon_symbols_o,
  input  wire  [3:0]       report_i,
  output logic             report_valid_o,
  output logic [3:0]       report_bits_o,
  output logic [IDX_W-1:0] report_idx_o,
  output logic             overflow_o
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_PW = c_AW + 1;
  localparam int c_CW = $clog2(ARM_CYCLES + 1);
  localparam logic [c_PW-1:0] c_DEPTH   = c_PW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_ARM_MAX = c_CW'(ARM_CYCLES);

  localparam logic [1:0] c_ARM    = 2'd0;
  localparam logic [1:0] c_STREAM = 2'd1;
  localparam logic [1:0] c_DRAIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_PW-1:0]  wr_q, wr_d, rd_q, rd_d, w_count_d;
  logic             ev_ready_q, ev_ready_d;
  logic [c_CW-1:0]  arm_cnt_q, arm_cnt_d;
  logic             mon_reset_q, mon_reset_d, mon_run_q, mon_run_d;
  logic [7:0]       mon_sym_q, mon_sym_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_prev_q, idx_prev_d;
  logic             run_prev_q, run_prev_d;
  logic             rep_valid_q, rep_valid_d;
  logic [3:0]       rep_bits_q, rep_bits_d;
  logic [IDX_W-1:0] rep_idx_q, rep_idx_d;
  logic             ovf_q, ovf_d;

  logic             w_empty, w_push, w_pop, w_arm_done, w_rearm;
  logic [7:0]       w_head;

  assign w_empty    = (wr_q == rd_q);
  assign w_head     = mem_q[rd_q[c_AW-1:0]];
  assign w_push     = ev.ev_valid & ev_ready_q;
  assign w_arm_done = (arm_cnt_q == c_ARM_MAX);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= c_ARM;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ARM:    if (w_arm_done && !w_empty) state_d = c_STREAM;
      c_STREAM: if (ev.flush) state_d = c_DRAIN;
      // A push landing this cycle keeps us draining so it is not lost.
      c_DRAIN:  if (w_empty && !w_push) state_d = c_ARM;
      default:  state_d = c_ARM;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    w_pop       = 1'b0;
    w_rearm     = 1'b0;
    mon_reset_d = mon_reset_q;
    mon_run_d   = mon_run_q;
    mon_sym_d   = mon_sym_q;
    idx_d       = idx_q;
    arm_cnt_d   = arm_cnt_q;
    case (state_q)
      c_ARM: begin
        if (state_d == c_STREAM) begin
          // Releasing reset and presenting the head on the same edge aligns
          // the first symbol with the monitor's start_of_data cycle.
          w_pop       = 1'b1;
          mon_reset_d = 1'b0;
          mon_run_d   = 1'b1;
          mon_sym_d   = w_head;
          idx_d       = '0;
        end else begin
          mon_reset_d = 1'b1;
          mon_run_d   = 1'b0;
          if (!w_arm_done) arm_cnt_d = arm_cnt_q + c_CW'(1);
        end
      end
      c_STREAM, c_DRAIN: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          mon_sym_d = w_head;
          mon_run_d = 1'b1;
          if (idx_q != {IDX_W{1'b1}}) idx_d = idx_q + IDX_W'(1);
        end else begin
          mon_run_d = 1'b0;
        end
        if (state_q == c_DRAIN && state_d == c_ARM) begin
          w_rearm     = 1'b1;
          arm_cnt_d   = '0;
          mon_run_d   = 1'b0;
          mon_reset_d = 1'b1;
        end
      end
      default: begin
        mon_reset_d = 1'b1;
        mon_run_d   = 1'b0;
      end
    endcase

    wr_d       = wr_q + c_PW'(w_push);
    rd_d       = rd_q + c_PW'(w_pop);
    w_count_d  = wr_d - rd_d;
    ev_ready_d = (w_count_d != c_DEPTH);

    // The monitor registers on the symbol edge, so its report for a symbol
    // shows up one cycle after that symbol was on the bus.
    rep_valid_d = 1'b0;
    rep_bits_d  = rep_bits_q;
    rep_idx_d   = rep_idx_q;
    if (run_prev_q && !mon_reset_q && (report_i != 4'd0)) begin
      rep_valid_d = 1'b1;
      rep_bits_d  = report_i;
      rep_idx_d   = idx_prev_q;
    end
    run_prev_d = mon_run_q & ~mon_reset_q;
    idx_prev_d = idx_q;

    ovf_d = ovf_q;
    if (w_rearm) ovf_d = 1'b0;
    if (ev.ev_valid && !ev_ready_q) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      ev_ready_q  <= 1'b0;
      arm_cnt_q   <= '0;
      mon_reset_q <= 1'b1;
      mon_run_q   <= 1'b0;
      mon_sym_q   <= 8'h00;
      idx_q       <= '0;
      idx_prev_q  <= '0;
      run_prev_q  <= 1'b0;
      rep_valid_q <= 1'b0;
      rep_bits_q  <= 4'h0;
      rep_idx_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ev_ready_q  <= ev_ready_d;
      arm_cnt_q   <= arm_cnt_d;
      mon_reset_q <= mon_reset_d;
      mon_run_q   <= mon_run_d;
      mon_sym_q   <= mon_sym_d;
      idx_q       <= idx_d;
      idx_prev_q  <= idx_prev_d;
      run_prev_q  <= run_prev_d;
      rep_valid_q <= rep_valid_d;
      rep_bits_q  <= rep_bits_d;
      rep_idx_q   <= rep_idx_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q[c_AW-1:0]] <= ev.ev_sym;
  end

  assign ev.ev_ready     = ev_ready_q;
  assign mon_reset_o     = mon_reset_q;
  assign mon_run_o       = mon_run_q;
  assign mon_symbols_o   = mon_sym_q;
  assign report_valid_o  = rep_valid_q;
  assign report_bits_o   = rep_bits_q;
  assign report_idx_o    = rep_idx_q;
  assign overflow_o      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ltl_symbol_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ltl_symbol_tx
// Description : Self-checking bench for ltl_symbol_tx. A queue-based model
//               predicts every output each cycle; directed traces pin the
//               model with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ltl_symbol_tx;
  localparam int DEPTH = 8;
  localparam int ARMC  = 10;
  localparam int IW    = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [3:0]    report_i = 4'h0;
  logic          mon_reset_o, mon_run_o, report_valid_o, overflow_o;
  logic [7:0]    mon_symbols_o;
  logic [3:0]    report_bits_o;
  logic [IW-1:0] report_idx_o;

  ltl_symbol_tx_if ev_if();

  ltl_symbol_tx #(.FIFO_DEPTH(DEPTH), .ARM_CYCLES(ARMC), .IDX_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .ev(ev_if),
    .mon_reset_o(mon_reset_o), .mon_run_o(mon_run_o), .mon_symbols_o(mon_symbols_o),
    .report_i(report_i), .report_valid_o(report_valid_o), .report_bits_o(report_bits_o),
    .report_idx_o(report_idx_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_phase   = 0;      // 0 waiting in reset, 1 streaming, 2 draining
  int            m_arm     = 0;
  logic [7:0]    m_q[$];
  bit            m_ready   = 0, m_rst = 1, m_run = 0, m_prevrun = 0, m_rv = 0, m_ovf = 0;
  logic [7:0]    m_sym     = 8'h00;
  logic [IW-1:0] m_idx     = '0, m_previdx = '0, m_ridx = '0;
  logic [3:0]    m_rb      = 4'h0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_arm = 0; m_q.delete(); m_ready = 0; m_rst = 1; m_run = 0;
      m_sym = 8'h00; m_idx = '0; m_prevrun = 0; m_previdx = '0;
      m_rv = 0; m_rb = 4'h0; m_ridx = '0; m_ovf = 0;
    end else begin
      bit push, was_empty;
      push      = ev_if.ev_valid && m_ready;
      was_empty = (m_q.size() == 0);
      m_rv = 0;
      if (m_prevrun && !m_rst && report_i != 4'h0) begin
        m_rv = 1; m_rb = report_i; m_ridx = m_previdx;
      end
      m_prevrun = m_run;
      m_previdx = m_idx;
      if (m_phase == 0) begin
        if (m_arm == ARMC && !was_empty) begin
          m_sym = m_q.pop_front(); m_run = 1; m_rst = 0; m_idx = '0; m_phase = 1;
        end else begin
          m_rst = 1; m_run = 0;
          if (m_arm < ARMC) m_arm++;
        end
      end else begin
        if (!was_empty) begin
          m_sym = m_q.pop_front(); m_run = 1;
          if (m_idx != {IW{1'b1}}) m_idx++;
        end else begin
          m_run = 0;
        end
        if (m_phase == 1 && ev_if.flush) m_phase = 2;
        else if (m_phase == 2 && was_empty && !push) begin
          m_phase = 0; m_arm = 0; m_ovf = 0; m_run = 0; m_rst = 1;
        end
      end
      if (push) m_q.push_back(ev_if.ev_sym);
      if (ev_if.ev_valid && !m_ready) m_ovf = 1;
      m_ready = (m_q.size() != DEPTH);
    end
  end

  // ---------------- compare process and logs ----------------
  bit         prev_rst_s = 1;
  int         rst_len = 0;
  logic [7:0] slog[$];
  logic [7:0] flog[$];
  int         alog[$];
  logic [19:0] rlog[$];

  always @(negedge clk) begin
    chk("mon_reset",    mon_reset_o,    m_rst);
    chk("mon_run",      mon_run_o,      m_run);
    chk("mon_symbols",  mon_symbols_o,  m_sym);
    chk("ev_ready",     ev_if.ev_ready, m_ready);
    chk("report_valid", report_valid_o, m_rv);
    chk("report_bits",  report_bits_o,  m_rb);
    chk("report_idx",   report_idx_o,   m_ridx);
    chk("overflow",     overflow_o,     m_ovf);
    if (mon_run_o) slog.push_back(mon_symbols_o);
    if (mon_run_o && prev_rst_s) flog.push_back(mon_symbols_o);
    if (mon_reset_o) rst_len++;
    else if (prev_rst_s) begin alog.push_back(rst_len); rst_len = 0; end
    if (report_valid_o) rlog.push_back({report_bits_o, report_idx_o});
    prev_rst_s = mon_reset_o;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit v, input logic [7:0] s, input bit f);
    @(negedge clk);
    ev_if.ev_valid = v; ev_if.ev_sym = s; ev_if.flush = f;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_log(input int n, input string nm);
    int k = 0;
    while (slog.size() < n && k < 100) begin @(posedge clk); k++; end
    chk(nm, slog.size(), n);
  endtask

  task automatic wait_sym(input logic [7:0] x, input string nm);
    int k = 0;
    bit found = 0;
    while (!found && k < 60) begin
      @(posedge clk); #1;
      if (mon_run_o === 1'b1 && mon_symbols_o === x) found = 1;
      k++;
    end
    chk(nm, found, 1);
  endtask

  task automatic wait_rst(input string nm);
    int k = 0;
    bit found = 0;
    while (!found && k < 60) begin
      @(posedge clk); #1;
      if (mon_reset_o === 1'b1) found = 1;
      k++;
    end
    chk(nm, found, 1);
  endtask

  task automatic pulse_report(input logic [3:0] r);
    @(posedge clk); #1 report_i = r;
    @(posedge clk); #1 report_i = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] s;
    ev_if.ev_valid = 0; ev_if.ev_sym = 8'h00; ev_if.flush = 0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mon_reset", mon_reset_o, 1);
    chk("rst_mon_run",   mon_run_o,   0);
    chk("rst_symbols",   mon_symbols_o, 0);
    chk("rst_ready",     ev_if.ev_ready, 0);
    chk("rst_rvalid",    report_valid_o, 0);
    chk("rst_ovf",       overflow_o, 0);
    chk("rst_ridx",      report_idx_o, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Fill the FIFO while the monitor is still held in reset; the 9th is dropped.
    for (int i = 0; i < 9; i++) begin
      s = 8'hA0 + 8'(i);
      cyc(1'b1, s, 1'b0);
    end
    #1 chk("full_ready_low", ev_if.ev_ready, 0);
    idle(1);
    #1 chk("full_overflow", overflow_o, 1);
    wait_log(8, "full_stream_count");
    for (int i = 0; i < 8; i++) begin
      s = 8'hA0 + 8'(i);
      chk("full_order", slog[i], s);
    end
    idle(4);
    chk("full_no_ninth", slog.size(), 8);
    chk("full_first_at_fall", flog[0], 8'hA0);

    // Flush with two entries in flight.
    cyc(1'b1, 8'hB1, 1'b0);
    cyc(1'b1, 8'hB2, 1'b1);
    idle(1);
    wait_rst("flush_rearm");
    chk("flush_ovf_cleared", overflow_o, 0);
    chk("flush_count", slog.size(), 10);
    chk("flush_b1", slog[8], 8'hB1);
    chk("flush_b2", slog[9], 8'hB2);

    // Basic stream as a fresh trace.
    cyc(1'b1, 8'h05, 1'b0);
    cyc(1'b1, 8'h1A, 1'b0);
    cyc(1'b1, 8'h80, 1'b0);
    idle(1);
    wait_log(13, "basic_count");
    chk("basic_s0", slog[10], 8'h05);
    chk("basic_s1", slog[11], 8'h1A);
    chk("basic_s2", slog[12], 8'h80);
    chk("basic_first_at_fall", flog[flog.size()-1], 8'h05);
    chk("basic_arm_len", alog[alog.size()-1] >= ARMC, 1);
    idle(3);
    #1 chk("basic_run_drop", mon_run_o, 0);

    // Gapped pushes; report on the last one tags idx 5 of this trace.
    cyc(1'b1, 8'h11, 1'b0);
    idle(3);
    #1 chk("gap_run_low", mon_run_o, 0);
    chk("gap_hold", mon_symbols_o, 8'h11);
    cyc(1'b1, 8'h22, 1'b0);
    idle(3);
    cyc(1'b1, 8'h33, 1'b0);
    idle(1);
    wait_sym(8'h33, "gap_wait33");
    pulse_report(4'b0010);
    idle(2);
    chk("gap_count", slog.size(), 16);
    chk("gap_tail", slog[15], 8'h33);
    chk("gap_rep_count", rlog.size(), 1);
    chk("gap_rep", rlog[0], {4'b0010, 16'd5});

    // Flush with an empty FIFO re-arms directly.
    cyc(1'b0, 8'h00, 1'b1);
    idle(1);
    wait_rst("empty_flush_rearm");

    // Report tagging on a new trace: index restarts at 0.
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h10, 1'b0);
    cyc(1'b1, 8'h90, 1'b0);
    idle(1);
    wait_sym(8'h90, "rep_wait90");
    pulse_report(4'b0001);
    idle(2);
    chk("rep_count", rlog.size(), 2);
    chk("rep_val", rlog[1], {4'b0001, 16'd2});
    chk("rep_first_at_fall", flog[flog.size()-1], 8'h00);

    // Asynchronous reset mid-stream with entries still queued.
    cyc(1'b0, 8'h00, 1'b1);
    idle(1);
    wait_rst("pre_async_rearm");
    for (int i = 0; i < 5; i++) begin
      s = 8'hC1 + 8'(i);
      cyc(1'b1, s, 1'b0);
    end
    idle(1);
    wait_sym(8'hC1, "async_wait_c1");
    #1 reset_n = 1'b0;
    #1;
    chk("async_mon_reset", mon_reset_o, 1);
    chk("async_mon_run",   mon_run_o, 0);
    chk("async_rvalid",    report_valid_o, 0);
    chk("async_ready",     ev_if.ev_ready, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n = slog.size();
    idle(25);
    chk("async_no_stale", slog.size(), n);
    cyc(1'b1, 8'h3C, 1'b0);
    idle(1);
    wait_log(n + 1, "async_new_count");
    chk("async_new_sym", slog[slog.size()-1], 8'h3C);
    chk("async_new_first", flog[flog.size()-1], 8'h3C);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
